wm_bay_scheduler: RTL and testbench

- Shares one washing-machine instance among NUM_REQ payment terminals (requesters).
- Latches each terminal's paid request, picks the next requester round-robin, and drives the machine's coin_in and double_wash inputs.
- Gates the pause request through to timer_pause, waits for wash_done, then returns a done pulse to the owning terminal.
- Sits between the terminal front-ends and the washing-machine core, in the same clock domain as the core.

---
 rtl/wm_sched_pkg.sv | 21 ++
 rtl/wm_rr_arbiter.sv | 31 +++
 rtl/wm_bay_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_wm_bay_scheduler.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wm_sched_pkg.sv
// Shared types and defaults for the washing-machine bay scheduler.
package wm_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RUN     = 2'd2,
        RELEASE = 2'd3
    } wm_state_e;

    localparam int          DEF_NUM_REQ     = 4;
    localparam int          DEF_COIN_CYCLES = 2;
    localparam logic [31:0] DEF_RUN_TIMEOUT = 32'd2_000_000_000;
    localparam int          SERVE_CNT_W     = 8;

    // Saturating increment for the per-requester serve counters.
    function automatic logic [SERVE_CNT_W-1:0] sat_inc(input logic [SERVE_CNT_W-1:0] v);
        return (v == {SERVE_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/wm_rr_arbiter.sv
// Round-robin picker: first pending index strictly after ptr_i, wrapping.
module wm_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] pending_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] win_o,
    output logic [IDX_W-1:0]   win_idx_o,
    output logic               any_o
);

    logic [IDX_W-1:0] cand;

    // Scan ptr+1 .. ptr+NUM_REQ; the first hit wins, later hits are ignored.
    always_comb begin
        win_o     = '0;
        win_idx_o = '0;
        any_o     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!any_o && pending_i[cand]) begin
                any_o        = 1'b1;
                win_idx_o    = cand;
                win_o[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wm_bay_scheduler.sv
// Shares one washing machine among NUM_REQ terminals: latches paid requests,
// dispatches round-robin (coin pulse, double-wash, pause gating), waits for
// wash_done or the run watchdog, then pulses done to the owner.
// Optional: define WM_SERVE_CNT_EN to add per-requester serve counters.
module wm_bay_scheduler
    import wm_sched_pkg::*;
#(
    parameter int                  NUM_REQ     = DEF_NUM_REQ,
    parameter int                  IDX_W       = 2,
    parameter int                  COIN_CYCLES = DEF_COIN_CYCLES,
    parameter int                  RUN_TO_W    = 32,
    parameter logic [RUN_TO_W-1:0] RUN_TIMEOUT = RUN_TO_W'(DEF_RUN_TIMEOUT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_dbl,
    input  logic [NUM_REQ-1:0] pause_in,
    input  logic               wm_wash_done,
    output logic               wm_coin_in,
    output logic               wm_double_wash,
    output logic               wm_timer_pause,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] pending,
    output logic [IDX_W-1:0]   owner_idx,
    output logic               busy,
    output logic               timeout_err
`ifdef WM_SERVE_CNT_EN
    ,
    output logic [NUM_REQ*SERVE_CNT_W-1:0] serve_cnt
`endif
);

    localparam int               CC_W      = (COIN_CYCLES > 1) ? $clog2(COIN_CYCLES) : 1;
    localparam logic [CC_W-1:0]  COIN_LAST = CC_W'(COIN_CYCLES - 1);

    wm_state_e            state_q, state_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   pending_q, pending_d;
    logic [NUM_REQ-1:0]   dbl_q, dbl_d;
    // Owner's double-wash copy: dbl_q[owner] may be rewritten by a new
    // request from the same terminal while its current wash is running.
    logic                 own_dbl_q, own_dbl_d;
    logic [CC_W-1:0]      coin_cnt_q, coin_cnt_d;
    logic [RUN_TO_W-1:0]  wdog_q, wdog_d;
    logic                 wash_q;          // registered wm_wash_done
    logic                 armed_q, armed_d; // wash_done seen low during RUN
    logic                 to_hit_q, to_hit_d;
    logic                 timeout_err_q, timeout_err_d;

    logic [NUM_REQ-1:0]   win;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_any;
    logic                 pause_own;
    logic [NUM_REQ-1:0]   owner_oh;
    logic                 in_dispatch;

    wm_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .pending_i (pending_q),
        .ptr_i     (ptr_q),
        .win_o     (win),
        .win_idx_o (win_idx),
        .any_o     (win_any)
    );

    assign owner_oh    = NUM_REQ'(1) << owner_q;
    assign pause_own   = pause_in[owner_q];
    assign in_dispatch = (state_q == LOAD) || (state_q == RUN);

    // State and datapath registers; reset abandons any wash in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            ptr_q         <= IDX_W'(NUM_REQ - 1);
            pending_q     <= '0;
            dbl_q         <= '0;
            own_dbl_q     <= 1'b0;
            coin_cnt_q    <= '0;
            wdog_q        <= '0;
            wash_q        <= 1'b0;
            armed_q       <= 1'b0;
            to_hit_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            ptr_q         <= ptr_d;
            pending_q     <= pending_d;
            dbl_q         <= dbl_d;
            own_dbl_q     <= own_dbl_d;
            coin_cnt_q    <= coin_cnt_d;
            wdog_q        <= wdog_d;
            wash_q        <= wm_wash_done;
            armed_q       <= armed_d;
            to_hit_q      <= to_hit_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state: dispatch FSM, watchdog, and the one-deep request latches.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        ptr_d         = ptr_q;
        pending_d     = pending_q;
        dbl_d         = dbl_q;
        own_dbl_d     = own_dbl_q;
        coin_cnt_d    = coin_cnt_q;
        wdog_d        = wdog_q;
        armed_d       = 1'b0;
        to_hit_d      = to_hit_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d    = LOAD;
                    owner_d    = win_idx;
                    ptr_d      = win_idx;
                    own_dbl_d  = dbl_q[win_idx];
                    pending_d  = pending_q & ~win;
                    coin_cnt_d = '0;
                end
            end
            LOAD: begin
                if (coin_cnt_q == COIN_LAST) begin
                    state_d = RUN;
                    wdog_d  = '0;
                end else begin
                    coin_cnt_d = coin_cnt_q + 1'b1;
                end
            end
            RUN: begin
                // A done level already present at RUN entry must drop first.
                armed_d = armed_q | ~wash_q;
                if (!pause_own && (wdog_q != RUN_TIMEOUT))
                    wdog_d = wdog_q + 1'b1;
                if (armed_q && wash_q) begin
                    state_d = RELEASE;
                end else if (wdog_q == RUN_TIMEOUT) begin
                    state_d       = RELEASE;
                    to_hit_d      = 1'b1;
                    timeout_err_d = 1'b1;
                end
            end
            RELEASE: begin
                state_d   = IDLE;
                wdog_d    = '0;
                own_dbl_d = 1'b0;
                to_hit_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // New requests only land in empty slots; a slot granted this edge
        // still reads as full, so a same-edge repeat is dropped.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && !pending_q[i]) begin
                pending_d[i] = 1'b1;
                dbl_d[i]     = req_dbl[i];
            end
        end
    end

    assign busy           = (state_q != IDLE);
    assign wm_coin_in     = (state_q == LOAD);
    assign wm_double_wash = in_dispatch & own_dbl_q;
    assign wm_timer_pause = (state_q == RUN) & pause_own;
    assign gnt            = in_dispatch ? owner_oh : '0;
    assign done           = (state_q == RELEASE) ? owner_oh : '0;
    assign owner_idx      = busy ? owner_q : '0;
    assign pending        = pending_q;
    assign timeout_err    = timeout_err_q;

`ifdef WM_SERVE_CNT_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        logic [SERVE_CNT_W-1:0] cnt_q;
        // Count normal completions for this requester, saturating.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                cnt_q <= '0;
            else if ((state_q == RELEASE) && !to_hit_q && (owner_q == IDX_W'(i)))
                cnt_q <= sat_inc(cnt_q);
        end
        assign serve_cnt[i*SERVE_CNT_W +: SERVE_CNT_W] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_wm_bay_scheduler.sv
// Directed self-checking bench for wm_bay_scheduler (NUM_REQ=4, RUN_TIMEOUT=500).
module tb_wm_bay_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, req_dbl, pause_in;
    logic       wm_wash_done;
    logic       wm_coin_in, wm_double_wash, wm_timer_pause;
    logic [3:0] gnt, done, pending;
    logic [1:0] owner_idx;
    logic       busy, timeout_err;
`ifdef WM_SERVE_CNT_EN
    logic [31:0] serve_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int exp_cnt [4];

    wm_bay_scheduler #(
        .NUM_REQ     (4),
        .IDX_W       (2),
        .COIN_CYCLES (2),
        .RUN_TO_W    (32),
        .RUN_TIMEOUT (32'd500)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_dbl        (req_dbl),
        .pause_in       (pause_in),
        .wm_wash_done   (wm_wash_done),
        .wm_coin_in     (wm_coin_in),
        .wm_double_wash (wm_double_wash),
        .wm_timer_pause (wm_timer_pause),
        .gnt            (gnt),
        .done           (done),
        .pending        (pending),
        .owner_idx      (owner_idx),
        .busy           (busy),
        .timeout_err    (timeout_err)
`ifdef WM_SERVE_CNT_EN
        ,
        .serve_cnt      (serve_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full dispatch for requester idx, starting at or before its first
    // coin cycle; optionally pulses req=inj during RUN.
    task automatic serve(input int idx, input logic dbl, input logic [3:0] inj);
        logic [3:0] oh;
        int n;
        oh = 4'b0001 << idx;
        n  = 0;
        while (wm_coin_in !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (wm_coin_in !== 1'b1) begin
            bad++;
            $display("FAIL serve%0d_coin_wait: coin=%b want 1", idx, wm_coin_in);
        end
        total++;
        if (gnt !== oh || owner_idx !== 2'(idx) || wm_double_wash !== dbl || busy !== 1'b1) begin
            bad++;
            $display("FAIL serve%0d_grant: gnt=%b owner=%0d dbl=%b busy=%b want gnt=%b owner=%0d dbl=%b busy=1",
                     idx, gnt, owner_idx, wm_double_wash, busy, oh, idx, dbl);
        end
        tick();
        total++;
        if (wm_coin_in !== 1'b1 || wm_double_wash !== dbl) begin
            bad++;
            $display("FAIL serve%0d_coin2: coin=%b dbl=%b want coin=1 dbl=%b", idx, wm_coin_in, wm_double_wash, dbl);
        end
        tick();
        total++;
        if (wm_coin_in !== 1'b0 || busy !== 1'b1 || gnt !== oh || wm_double_wash !== dbl) begin
            bad++;
            $display("FAIL serve%0d_run: coin=%b busy=%b gnt=%b dbl=%b want coin=0 busy=1 gnt=%b dbl=%b",
                     idx, wm_coin_in, busy, gnt, wm_double_wash, oh, dbl);
        end
        req = inj;
        tick();
        req = 4'b0000;
        tick();
        wm_wash_done = 1'b1;
        tick();
        wm_wash_done = 1'b0;
        total++;
        if (done !== 4'b0000 || busy !== 1'b1) begin
            bad++;
            $display("FAIL serve%0d_done_early: done=%b busy=%b want done=0000 busy=1", idx, done, busy);
        end
        tick();
        total++;
        if (done !== oh || gnt !== 4'b0000 || wm_double_wash !== 1'b0) begin
            bad++;
            $display("FAIL serve%0d_release: done=%b gnt=%b dbl=%b want done=%b gnt=0000 dbl=0",
                     idx, done, gnt, wm_double_wash, oh);
        end
        exp_cnt[idx]++;
        tick();
        total++;
        if (busy !== 1'b0 || done !== 4'b0000 || owner_idx !== 2'd0 || wm_coin_in !== 1'b0) begin
            bad++;
            $display("FAIL serve%0d_idle_gap: busy=%b done=%b owner=%0d coin=%b want all 0",
                     idx, busy, done, owner_idx, wm_coin_in);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_dbl = '0; pause_in = '0; wm_wash_done = 1'b0;
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
        tick(); tick();
        total++;
        if ({wm_coin_in, wm_double_wash, wm_timer_pause, gnt, done, pending, owner_idx, busy, timeout_err} !== '0) begin
            bad++;
            $display("FAIL reset_state: coin=%b dbl=%b pause=%b gnt=%b done=%b pend=%b owner=%0d busy=%b to=%b want all 0",
                     wm_coin_in, wm_double_wash, wm_timer_pause, gnt, done, pending, owner_idx, busy, timeout_err);
        end
        rst = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || pending !== 4'b0000) begin
            bad++;
            $display("FAIL reset_release: busy=%b pend=%b want 0/0000", busy, pending);
        end
    endtask

    task automatic test_contention();
        req = 4'b1011;
        tick();
        req = 4'b0000;
        total++;
        if (pending !== 4'b1011 || busy !== 1'b0) begin
            bad++;
            $display("FAIL cont_latch: pend=%b busy=%b want 1011/0", pending, busy);
        end
        serve(0, 1'b0, 4'b0000);
        serve(1, 1'b0, 4'b0000);
        serve(3, 1'b0, 4'b0001);
        total++;
        if (pending !== 4'b0001) begin
            bad++;
            $display("FAIL cont_requeue: pend=%b want 0001", pending);
        end
        serve(0, 1'b0, 4'b0000);
    endtask

    task automatic test_single();
        req = 4'b0100; req_dbl = 4'b0100;
        tick();
        req = 4'b0000; req_dbl = 4'b0000;
        total++;
        if (pending !== 4'b0100 || wm_coin_in !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_latch: pend=%b coin=%b busy=%b want 0100/0/0", pending, wm_coin_in, busy);
        end
        tick();
        total++;
        if (wm_coin_in !== 1'b1 || pending !== 4'b0000) begin
            bad++;
            $display("FAIL single_latency: coin=%b pend=%b want 1/0000", wm_coin_in, pending);
        end
        serve(2, 1'b1, 4'b0000);
    endtask

    task automatic test_duplicate();
        req = 4'b0010;
        tick();
        tick();
        req = 4'b0000;
        total++;
        if (pending !== 4'b0000 || wm_coin_in !== 1'b1) begin
            bad++;
            $display("FAIL dup_ignored: pend=%b coin=%b want 0000/1", pending, wm_coin_in);
        end
        serve(1, 1'b0, 4'b0000);
        tick(); tick(); tick();
        total++;
        if (busy !== 1'b0 || pending !== 4'b0000) begin
            bad++;
            $display("FAIL dup_single_dispatch: busy=%b pend=%b want 0/0000", busy, pending);
        end
        req = 4'b0010;
        tick();
        req = 4'b0000;
        serve(1, 1'b0, 4'b0010);
        total++;
        if (pending !== 4'b0010) begin
            bad++;
            $display("FAIL owner_requeue: pend=%b want 0010", pending);
        end
        serve(1, 1'b0, 4'b0000);
    endtask

    task automatic test_pause_timeout();
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        total++;
        if (wm_coin_in !== 1'b1 || gnt !== 4'b0010) begin
            bad++;
            $display("FAIL to_load: coin=%b gnt=%b want 1/0010", wm_coin_in, gnt);
        end
        tick(); tick();
        total++;
        if (busy !== 1'b1 || wm_coin_in !== 1'b0) begin
            bad++;
            $display("FAIL to_run: busy=%b coin=%b want 1/0", busy, wm_coin_in);
        end
        repeat (50) tick();
        pause_in = 4'b0101;
        #1;
        total++;
        if (wm_timer_pause !== 1'b0) begin
            bad++;
            $display("FAIL pause_nonowner: pause=%b want 0", wm_timer_pause);
        end
        repeat (10) tick();
        pause_in = 4'b0010;
        #1;
        for (int i = 0; i < 100; i++) begin
            total++;
            if (wm_timer_pause !== 1'b1) begin
                bad++;
                $display("FAIL pause_owner_c%0d: pause=%b want 1", i, wm_timer_pause);
            end
            tick();
        end
        pause_in = 4'b0000;
        #1;
        total++;
        if (wm_timer_pause !== 1'b0) begin
            bad++;
            $display("FAIL pause_release: pause=%b want 0", wm_timer_pause);
        end
        repeat (439) tick();
        total++;
        if (busy !== 1'b1 || timeout_err !== 1'b0 || done !== 4'b0000) begin
            bad++;
            $display("FAIL to_499: busy=%b to=%b done=%b want 1/0/0000", busy, timeout_err, done);
        end
        tick();
        total++;
        if (busy !== 1'b1 || gnt !== 4'b0010 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL to_500_not_early: busy=%b gnt=%b to=%b want 1/0010/0", busy, gnt, timeout_err);
        end
        tick();
        total++;
        if (done !== 4'b0010 || timeout_err !== 1'b1 || gnt !== 4'b0000) begin
            bad++;
            $display("FAIL to_release: done=%b to=%b gnt=%b want 0010/1/0000", done, timeout_err, gnt);
        end
        tick();
        total++;
        if (busy !== 1'b0 || timeout_err !== 1'b1 || done !== 4'b0000) begin
            bad++;
            $display("FAIL to_sticky: busy=%b to=%b done=%b want 0/1/0000", busy, timeout_err, done);
        end
`ifdef WM_SERVE_CNT_EN
        for (int i = 0; i < 4; i++) begin
            total++;
            if (serve_cnt[i*8 +: 8] !== 8'(exp_cnt[i])) begin
                bad++;
                $display("FAIL serve_cnt%0d: got %0d want %0d", i, serve_cnt[i*8 +: 8], exp_cnt[i]);
            end
        end
`endif
    endtask

    task automatic test_reset_mid();
        req = 4'b1001;
        tick();
        req = 4'b0000;
        tick();
        total++;
        if (wm_coin_in !== 1'b1) begin
            bad++;
            $display("FAIL rst_load_setup: coin=%b want 1", wm_coin_in);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({wm_coin_in, wm_double_wash, wm_timer_pause, gnt, done, pending, owner_idx, busy, timeout_err} !== '0) begin
            bad++;
            $display("FAIL rst_in_load: coin=%b gnt=%b done=%b pend=%b owner=%0d busy=%b to=%b want all 0",
                     wm_coin_in, gnt, done, pending, owner_idx, busy, timeout_err);
        end
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (done !== 4'b0000 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rst_load_quiet_c%0d: done=%b busy=%b want 0000/0", i, done, busy);
            end
        end
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tick(); tick(); tick();
        total++;
        if (busy !== 1'b1 || wm_coin_in !== 1'b0 || gnt !== 4'b0100) begin
            bad++;
            $display("FAIL rst_run_setup: busy=%b coin=%b gnt=%b want 1/0/0100", busy, wm_coin_in, gnt);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({wm_coin_in, wm_double_wash, wm_timer_pause, gnt, done, pending, owner_idx, busy, timeout_err} !== '0) begin
            bad++;
            $display("FAIL rst_in_run: coin=%b gnt=%b done=%b pend=%b owner=%0d busy=%b want all 0",
                     wm_coin_in, gnt, done, pending, owner_idx, busy);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (done !== 4'b0000 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rst_run_quiet_c%0d: done=%b busy=%b want 0000/0", i, done, busy);
            end
        end
`ifdef WM_SERVE_CNT_EN
        total++;
        if (serve_cnt !== 32'd0) begin
            bad++;
            $display("FAIL rst_serve_cnt: got %h want 0", serve_cnt);
        end
`endif
        req = 4'b0001;
        tick();
        req = 4'b0000;
        serve(0, 1'b0, 4'b0000);
`ifdef WM_SERVE_CNT_EN
        total++;
        if (serve_cnt !== 32'h0000_0001) begin
            bad++;
            $display("FAIL post_rst_serve_cnt: got %h want 00000001", serve_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_duplicate();
        test_pause_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
